alu_op_issuer: RTL and testbench
================================

ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 Parameter: CNT_W, 16, width of completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  issuer can accept request.
REQ-006 req_op  input  3  op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 101-111 undefined.
REQ-007 req_a  input  16  operand A.
REQ-008 req_b  input  16  operand B.
REQ-009 req_chain  input  1  1 = use last result as operand A, ignore req_a.
REQ-010 alu_in1  output  16  registered operand A to the 16-bit ALU.
REQ-011 alu_in2  output  16  registered operand B to the 16-bit ALU.
REQ-012 alu_sel  output  3  registered op select to the 16-bit ALU.
REQ-013 alu_out  input  16  combinational ALU result (valid one cycle after alu_* change).
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_data  output  16  captured result.
REQ-017 rsp_err  output  1  illegal-op response flag (see Configuration).
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 op_count  output  CNT_W  number of completed response handshakes.

Function
REQ-020 FSM states IDLE, EXEC, RESP; req_ready SHALL equal (state==IDLE) only.
REQ-021 IDLE: on req_valid&req_ready at edge E0, register alu_in1 (req_a or last_result if req_chain), alu_in2=req_b, alu_sel=req_op; go EXEC.
REQ-022 EXEC: at edge E1, capture alu_out into rsp_data and last_result; go RESP.
REQ-023 RESP: rsp_valid=1; rsp_data/rsp_err stable until rsp_valid&rsp_ready; on handshake go IDLE, op_count+1.
REQ-024 Latency: rsp_valid asserted in the cycle following E1 (2 clocks after accept); min throughput 1 op / 3 clocks.
REQ-025 alu_in1/alu_in2/alu_sel SHALL hold last issued values outside EXEC (no glitching of ALU inputs).
REQ-026 All arithmetic modulo 2^16 (ALU behaviour); issuer adds no width extension.
REQ-027 op_count wraps from 2^CNT_W-1 to 0 without flag.
REQ-028 req_valid while not IDLE: ignored, request not consumed.
REQ-029 req_chain on first op after reset: operand A = 0x0000.
REQ-030 rsp_ready high with rsp_valid low: no effect.

Reset
REQ-031 rst high SHALL immediately force state IDLE, abandoning any in-flight op with no response.
REQ-032 Reset values: alu_in1=0, alu_in2=0, alu_sel=000, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, op_count=0, last_result=0.
REQ-033 req_ready SHALL be 1 during and after reset (IDLE).

Configuration
REQ-034 Macro ALU_ISSUER_OPCHK_EN defined: req_op 101-111 accepted but not issued; alu_* unchanged; IDLE->RESP directly with rsp_data=0, rsp_err=1, last_result unchanged; latency 1 clock.
REQ-035 Macro undefined: all ops issued via EXEC normally; rsp_err tied 0; illegal ops return whatever ALU produces (0x0000).

Verification
REQ-036 ADD a=0x0003 b=0x0004 -> rsp_data=0x0007, rsp_valid 2 clocks after accept, op_count=1.
REQ-037 SUB 0x0000-0x0001 -> 0xFFFF; then ADD 0xFFFF+0x0001 -> 0x0000.
REQ-038 rsp_ready held 0 for 5 clocks in RESP -> rsp_data stable, req_ready=0, busy=1; release -> IDLE next clock.
REQ-039 ADD 5+3 -> 0x0008, then XOR req_chain=1 b=0x000F -> alu_in1=0x0008, rsp_data=0x0007.
REQ-040 op 110, a=0x1234: macro defined -> rsp_err=1, rsp_data=0, alu_sel unchanged; undefined -> rsp_err=0, rsp_data=0x0000.
REQ-041 rst asserted mid-EXEC -> all outputs to reset values same cycle, no response produced, req_ready=1.

Source files
------------

// File: rtl/alu_op_issuer.sv
// Issues one request at a time to an external combinational 16-bit ALU and returns the captured result.
// Optional build macro ALU_ISSUER_OPCHK_EN: opcodes 101-111 are answered with an error response and never issued.
module alu_op_issuer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic             req_chain,
  output logic [15:0]      alu_in1,
  output logic [15:0]      alu_in2,
  output logic [2:0]       alu_sel,
  input  logic [15:0]      alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        illegal;
  logic [15:0] last_result;

  assign accept    = req_valid & (state == IDLE);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef ALU_ISSUER_OPCHK_EN
  assign illegal = (req_op > 3'd4);
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = illegal ? RESP : EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU inputs only move on an issued accept, so they hold between ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_sel     <= '0;
      rsp_data    <= '0;
      last_result <= '0;
      op_count    <= '0;
    end else begin
      if (accept && !illegal) begin
        alu_in1 <= req_chain ? last_result : req_a;
        alu_in2 <= req_b;
        alu_sel <= req_op;
      end
      if (accept && illegal) rsp_data <= '0;
      if (state == EXEC) begin
        rsp_data    <= alu_out;
        last_result <= alu_out;
      end
      if (state == RESP && rsp_ready) op_count <= op_count + CNT_W'(1);
    end
  end

`ifdef ALU_ISSUER_OPCHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rsp_err <= 1'b0;
    else if (accept) rsp_err <= illegal;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed + randomized bench for alu_op_issuer with a behavioural ALU and transaction-level reference model.
module tb_alu_op_issuer;
  localparam int CW = 4;

`ifdef ALU_ISSUER_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready;
  logic [2:0]    req_op = '0;
  logic [15:0]   req_a = '0, req_b = '0;
  logic          req_chain = 1'b0;
  logic [15:0]   alu_in1, alu_in2, alu_out;
  logic [2:0]    alu_sel;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [15:0]   rsp_data;
  logic [CW-1:0] op_count;

  int vectors = 0;
  int errs    = 0;

  // reference state, tracked at transaction level
  logic [15:0] last_res = '0;
  int          cnt = 0;
  logic [15:0] exp_in1 = '0, exp_in2 = '0;
  logic [2:0]  exp_sel = '0;

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0:    return 16'((32'(a) + 32'(b)) % 65536);
      3'd1:    return 16'((32'(a) + 65536 - 32'(b)) % 65536);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_out = ref_alu(alu_sel, alu_in1, alu_in2);

  alu_op_issuer #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_chain(req_chain),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ch, input int hold);
    logic [15:0] ea, er;
    bit bad;
    bad = OPCHK && (op > 3'd4);
    ea  = ch ? last_res : a;
    er  = bad ? 16'h0000 : ref_alu(op, ea, b);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_chain = ch;
    chk("ready_idle", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    if (!bad) begin
      exp_in1 = ea; exp_in2 = b; exp_sel = op;
      chk("exec_valid", 32'(rsp_valid), 32'd0);
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_in1", 32'(alu_in1), 32'(exp_in1));
      chk("exec_in2", 32'(alu_in2), 32'(exp_in2));
      chk("exec_sel", 32'(alu_sel), 32'(exp_sel));
      step();
      last_res = er;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(er));
    chk("rsp_err", 32'(rsp_err), 32'(bad));
    chk("hold_in1", 32'(alu_in1), 32'(exp_in1));
    chk("hold_sel", 32'(alu_sel), 32'(exp_sel));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_a = 16'($urandom); req_op = 3'($urandom_range(0, 4));
      step();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'(er));
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cnt = (cnt + 1) % (1 << CW);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_valid", 32'(rsp_valid), 32'd0);
    chk("op_count", 32'(op_count), 32'(cnt));
    chk("done_in2", 32'(alu_in2), 32'(exp_in2));
  endtask

  initial begin
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_in1", 32'(alu_in1), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    step();

    // rsp_ready with nothing pending has no effect
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    chk("idle_rdy_count", 32'(op_count), 32'd0);

    // chain on first op after reset uses A = 0
    do_op(3'd0, 16'h9999, 16'h0011, 1'b1, 0);
    do_op(3'd0, 16'h0003, 16'h0004, 1'b0, 0);
    do_op(3'd1, 16'h0000, 16'h0001, 1'b0, 0);
    do_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 0);
    do_op(3'd2, 16'hF0F0, 16'h3C3C, 1'b0, 5);
    do_op(3'd0, 16'h0005, 16'h0003, 1'b0, 0);
    do_op(3'd4, 16'hDEAD, 16'h000F, 1'b1, 0);
    do_op(3'd6, 16'h1234, 16'h5678, 1'b0, 1);
    do_op(3'd3, 16'h0100, 16'h0001, 1'b1, 0);

    for (int n = 0; n < 40; n++)
      do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    // reset in the middle of EXEC abandons the op
    req_valid = 1'b1; req_op = 3'd0; req_a = 16'h0001; req_b = 16'h0002; req_chain = 1'b0;
    step();
    req_valid = 1'b0;
    rst = 1'b1; #1;
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid", 32'(rsp_valid), 32'd0);
    chk("mid_in1", 32'(alu_in1), 32'd0);
    chk("mid_in2", 32'(alu_in2), 32'd0);
    chk("mid_sel", 32'(alu_sel), 32'd0);
    chk("mid_data", 32'(rsp_data), 32'd0);
    chk("mid_err", 32'(rsp_err), 32'd0);
    chk("mid_count", 32'(op_count), 32'd0);
    @(negedge clk); rst = 1'b0;
    last_res = '0; cnt = 0; exp_in1 = '0; exp_in2 = '0; exp_sel = '0;
    repeat (3) begin
      step();
      chk("no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_op(3'd4, 16'h5555, 16'h000F, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    errs++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $fatal(1, "timeout");
  end
endmodule
